// File: rtl/frame_buffer_writer_pkg.sv
// Shared video definitions for the frame buffer write and display paths:
// frame geometry, the RGB444 pixel layout and the capture FSM state type.
package frame_buffer_writer_pkg;

    localparam int VID_H_RES  = 320;
    localparam int VID_V_RES  = 240;
    localparam int VID_ADDR_W = 17;

    // Packed RGB444 pixel as stored in the BRAM: {R, G, B}.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_WAIT = 2'd1,
        S_CAP  = 2'd2
    } fbw_state_t;

    // The red nibble comes from the first camera byte; the second byte
    // carries green in its upper nibble and blue in its lower nibble.
    function automatic rgb444_t rgb444_pack(input logic [3:0] r, input logic [7:0] gb);
        rgb444_t p;
        p.r = r;
        p.g = gb[7:4];
        p.b = gb[3:0];
        return p;
    endfunction

endpackage

// File: rtl/frame_buffer_writer_edge_detect.sv
// Registers a level and reports its rising and falling edges as
// single-cycle pulses in the same cycle the new level is first seen.
module frame_buffer_writer_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    // Previous-cycle copy of the level, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Write side of the RGB444 frame buffer: assembles byte-serial camera
// pixels, drives the BRAM write port and reports frame completion.
//
// state  | meaning
// S_SYNC | after reset; waiting for vsync high so no partial frame is taken
// S_WAIT | vertical blanking; capture starts on the vsync fall
// S_CAP  | capturing lines; the vsync rise closes the frame
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int H_RES  = VID_H_RES,
    parameter int V_RES  = VID_V_RES,
    parameter int ADDR_W = VID_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    input  logic              i_vsync,
    input  logic              i_href,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [11:0]       o_wr_data,
    output logic              o_frame_done,
    output logic              o_frame_ok,
    output logic              o_err_sticky
);

    localparam int X_W = $clog2(H_RES + 1);
    localparam int Y_W = $clog2(V_RES + 1);

    localparam logic [X_W-1:0]    X_END     = X_W'(H_RES);
    localparam logic [Y_W-1:0]    Y_END     = Y_W'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    fbw_state_t state;
    fbw_state_t state_next;

    logic              cap_start;
    logic              cap_end;
    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_rise_unused;
    logic              href_fall;

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              phase;
    logic [3:0]        r_lat;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;

    logic              in_cap;
    logic              byte_take;
    logic              pix_fits;
    logic              line_end;
    logic              line_counts;
    logic [Y_W-1:0]    y_at_end;
    logic              err_at_end;

    frame_buffer_writer_edge_detect u_vsync_edge (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (i_vsync),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    frame_buffer_writer_edge_detect u_href_edge (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (i_href),
        .rise  (href_rise_unused),
        .fall  (href_fall)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and capture start/end strobes. In S_WAIT vsync is known to
    // have been high, so its falling edge is the first low cycle.
    always_comb begin
        state_next = state;
        cap_start  = 1'b0;
        cap_end    = 1'b0;
        unique case (state)
            S_SYNC: begin
                if (i_vsync) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vsync_fall) begin
                    state_next = S_CAP;
                    cap_start  = 1'b1;
                end
            end
            S_CAP: begin
                if (vsync_rise) begin
                    state_next = S_WAIT;
                    cap_end    = 1'b1;
                end
            end
            default: begin
                state_next = S_SYNC;
            end
        endcase
    end

    // Bytes arriving in the cycle that closes the frame are dropped.
    assign in_cap      = (state == S_CAP);
    assign byte_take   = in_cap && !vsync_rise && i_href && i_byte_valid;
    assign pix_fits    = (x < X_END) && (y < Y_END);
    assign line_end    = in_cap && href_fall;
    assign line_counts = line_end && (x != '0) && (y < Y_END);
    assign y_at_end    = line_counts ? (y + Y_W'(1)) : y;
    assign err_at_end  = o_err_sticky || (line_end && phase);

    // Pixel assembly, x/y and address counters, write port and frame flags.
    // The address is a running count within a line; each counted line end
    // reloads it from an accumulated line base so short lines cannot shift
    // later lines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x            <= '0;
            y            <= '0;
            phase        <= 1'b0;
            r_lat        <= '0;
            addr         <= '0;
            line_base    <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_err_sticky <= 1'b0;
        end else begin
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            if (cap_start) begin
                x            <= '0;
                y            <= '0;
                phase        <= 1'b0;
                addr         <= '0;
                line_base    <= '0;
                o_err_sticky <= 1'b0;
            end else if (in_cap) begin
                if (byte_take) begin
                    if (!phase) begin
                        r_lat <= i_byte[3:0];
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (pix_fits) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= addr;
                            o_wr_data <= rgb444_pack(r_lat, i_byte);
                            addr      <= addr + ADDR_W'(1);
                            x         <= x + X_W'(1);
                        end else begin
                            o_err_sticky <= 1'b1;
                        end
                    end
                end
                if (line_end) begin
                    if (phase) begin
                        o_err_sticky <= 1'b1;
                        phase        <= 1'b0;
                    end
                    if (line_counts) begin
                        y         <= y_at_end;
                        x         <= '0;
                        line_base <= line_base + LINE_STEP;
                        addr      <= line_base + LINE_STEP;
                    end
                end
                if (cap_end) begin
                    o_frame_done <= 1'b1;
                    o_frame_ok   <= (y_at_end == Y_END) && !err_at_end;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer. Runs with a reduced line count
// (V_RES = 8) and full line width to keep whole frames short.
module tb_frame_buffer_writer;

    localparam int H  = 320;
    localparam int V  = 8;
    localparam int AW = 17;

    logic          clk;
    logic          rst;
    logic          byte_valid;
    logic [7:0]    byte_val;
    logic          vsync;
    logic          href;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done;
    logic          frame_ok;
    logic          err_sticky;

    int passed = 0;
    int total  = 0;

    logic [31:0] q_addr[$];
    logic [11:0] q_data[$];

    frame_buffer_writer #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (AW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_byte_valid (byte_valid),
        .i_byte       (byte_val),
        .i_vsync      (vsync),
        .i_href       (href),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_frame_done (frame_done),
        .o_frame_ok   (frame_ok),
        .o_err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every BRAM write for later comparison.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            q_addr.push_back(32'(wr_addr));
            q_data.push_back(wr_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] pix_val(input logic [31:0] a);
        return {a[3:0], a[11:4]};
    endfunction

    task automatic send_line(input int nbytes, input int base, input bit close = 1'b1);
        logic [31:0] a;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            a          = 32'(base + i / 2);
            href       = 1'b1;
            byte_valid = 1'b1;
            byte_val   = (i % 2 == 0) ? {~a[3:0], a[3:0]} : a[11:4];
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_val   = 8'h00;
        if (close) begin
            href = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        repeat (10) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame(input logic exp_ok);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("frame_ok", frame_ok, exp_ok);
        @(negedge clk);
        chk("frame_done_single", frame_done, 1'b0);
    endtask

    task automatic check_writes(input int n, input int base);
        int got;
        got = q_addr.size();
        chk("wr_count", got, n);
        for (int k = 0; k < got && k < n; k++) begin
            chk("wr_addr", q_addr[k], 32'(base + k));
            chk("wr_data", 32'(q_data[k]), 32'(pix_val(32'(base + k))));
        end
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_val   = 8'h00;
        vsync      = 1'b0;
        href       = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_ok", frame_ok, 1'b0);
        chk("rst_err", err_sticky, 1'b0);
        rst = 1'b0;

        // Stream without a preceding vsync pulse must not be captured.
        send_line(20, 0);
        check_writes(0, 0);

        // Full frame.
        start_frame();
        for (int y = 0; y < V; y++) send_line(2 * H, y * H);
        check_writes(H * V, 0);
        chk("full_err", err_sticky, 1'b0);
        end_frame(1'b1);

        // Single pixel 0x0A,0x5C: presented exactly one cycle after the 2nd strobe.
        start_frame();
        @(negedge clk);
        href       = 1'b1;
        byte_valid = 1'b1;
        byte_val   = 8'h0A;
        @(negedge clk);
        byte_val   = 8'h5C;
        chk("pix_not_early", wr_en, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("pix_wr_en", wr_en, 1'b1);
        chk("pix_addr", 32'(wr_addr), 32'd0);
        chk("pix_data", 32'(wr_data), 32'h0A5C);
        @(negedge clk);
        chk("pix_one_cycle", wr_en, 1'b0);
        href = 1'b0;
        repeat (2) @(negedge clk);
        q_addr.delete();
        q_data.delete();
        chk("pix_err", err_sticky, 1'b0);

        // Overlong line: 321st pixel dropped, next line base unaffected.
        send_line(2 * H + 2, H);
        check_writes(H, H);
        chk("overrun_err", err_sticky, 1'b1);

        // Odd byte count: trailing half pixel discarded.
        send_line(2 * H - 3, 2 * H);
        check_writes(H - 2, 2 * H);
        send_line(4, 3 * H);
        check_writes(2, 3 * H);

        // href pulse with no pixels does not count as a line.
        @(negedge clk);
        href = 1'b1;
        repeat (3) @(negedge clk);
        href = 1'b0;
        repeat (2) @(negedge clk);
        send_line(2, 4 * H);
        check_writes(1, 4 * H);
        chk("short_frame_err", err_sticky, 1'b1);
        end_frame(1'b0);

        // New capture clears the error; an extra line past V_RES is dropped.
        start_frame();
        chk("err_cleared", err_sticky, 1'b0);
        for (int y = 0; y < V; y++) send_line(2 * H, y * H);
        check_writes(H * V, 0);
        chk("before_extra_err", err_sticky, 1'b0);
        send_line(4, H * V);
        check_writes(0, 0);
        chk("extra_line_err", err_sticky, 1'b1);
        end_frame(1'b0);

        // Reset in the middle of line 3.
        start_frame();
        for (int y = 0; y < 3; y++) send_line(2 * H, y * H);
        send_line(100, 3 * H, 1'b0);
        rst  = 1'b1;
        href = 1'b0;
        repeat (3) @(negedge clk);
        check_writes(3 * H + 50, 0);
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_err", err_sticky, 1'b0);
        rst = 1'b0;
        send_line(40, 0);
        check_writes(0, 0);
        start_frame();
        send_line(4, 0);
        check_writes(2, 0);
        end_frame(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
